// File: rtl/instr_fetch_if.sv
// Bus bundle for the fetch unit: instruction-memory request/response,
// redirect input and the decoder-facing instruction stream.
interface instr_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        output instr,
        output instr_pc,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        input  instr,
        input  instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues sequential word fetches, pairs in-order
// responses with their PCs and buffers them for the decoder; redirects flush.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input logic           clk,
    input logic           rst,
    instr_fetch_if.master bus
);
    localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            CW       = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW:0]   LIMIT    = (CW + 1)'(DEPTH);

    logic [31:0]   r_pc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_dropCnt;
    logic [31:0]   r_pendPc   [DEPTH];
    logic [PW-1:0] r_pendWr;
    logic [PW-1:0] r_pendRd;
    logic [31:0]   r_fifoData [DEPTH];
    logic [31:0]   r_fifoPc   [DEPTH];
    logic [PW-1:0] r_fifoWr;
    logic [PW-1:0] r_fifoRd;
    logic [CW-1:0] r_fifoCount;

    logic [CW:0]   w_inFlight;
    logic          w_reqValid;
    logic          w_reqFire;
    logic          w_respIn;
    logic          w_respKeep;
    logic          w_instrValid;
    logic          w_pop;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Discarded responses still occupy in-flight slots, so the limit
    // covers everything requested but not yet handed to the decoder.
    assign w_inFlight   = {1'b0, r_outstanding} + {1'b0, r_fifoCount};
    assign w_reqValid   = !rst && !bus.redirect_valid && (w_inFlight < LIMIT);
    assign w_reqFire    = w_reqValid && bus.imem_req_ready;
    assign w_respIn     = bus.imem_resp_valid && (r_outstanding != '0);
    assign w_respKeep   = w_respIn && !bus.redirect_valid && (r_dropCnt == '0);
    assign w_instrValid = !rst && (r_fifoCount != '0);
    assign w_pop        = w_instrValid && bus.instr_ready;

    assign bus.imem_req_valid = w_reqValid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.instr_valid    = w_instrValid;
    assign bus.instr          = w_instrValid ? r_fifoData[r_fifoRd] : '0;
    assign bus.instr_pc       = w_instrValid ? r_fifoPc[r_fifoRd]   : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_dropCnt     <= '0;
            r_pendWr      <= '0;
            r_pendRd      <= '0;
            r_fifoWr      <= '0;
            r_fifoRd      <= '0;
            r_fifoCount   <= '0;
        end else begin
            if (bus.redirect_valid) begin
                r_pc <= {bus.redirect_pc[31:2], 2'b00};
            end else if (w_reqFire) begin
                r_pc <= r_pc + 32'd4;
            end

            if (w_reqFire) begin
                r_pendWr <= nextPtr(r_pendWr);
            end
            if (w_respIn) begin
                r_pendRd <= nextPtr(r_pendRd);
            end

            case ({w_reqFire, w_respIn})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase

            // Everything still in flight at a redirect belongs to the old path.
            if (bus.redirect_valid) begin
                r_dropCnt <= r_outstanding - CW'(w_respIn);
            end else if (w_respIn && (r_dropCnt != '0)) begin
                r_dropCnt <= r_dropCnt - CW'(1);
            end

            if (bus.redirect_valid) begin
                r_fifoWr    <= '0;
                r_fifoRd    <= '0;
                r_fifoCount <= '0;
            end else begin
                if (w_respKeep) begin
                    r_fifoWr <= nextPtr(r_fifoWr);
                end
                if (w_pop) begin
                    r_fifoRd <= nextPtr(r_fifoRd);
                end
                case ({w_respKeep, w_pop})
                    2'b10:   r_fifoCount <= r_fifoCount + CW'(1);
                    2'b01:   r_fifoCount <= r_fifoCount - CW'(1);
                    default: r_fifoCount <= r_fifoCount;
                endcase
            end
        end
    end

    // Storage arrays need no reset; the output mux hides stale contents.
    always_ff @(posedge clk) begin
        if (w_reqFire) begin
            r_pendPc[r_pendWr] <= r_pc;
        end
        if (w_respKeep) begin
            r_fifoData[r_fifoWr] <= bus.imem_resp_data;
            r_fifoPc[r_fifoWr]   <= r_pendPc[r_pendRd];
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios then random traffic,
// all compared against a queue-based model of the fetch stream.
module tb_instr_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 4;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memEntry_t;

    logic clk = 1'b0;
    logic rst;
    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checkCount = 0;
    int          passCount  = 0;
    int          cycle      = 0;
    int          latMin     = 1;
    int          latMax     = 1;
    logic        spurious   = 1'b0;
    int          acceptCount  = 0;
    int          discardCount = 0;

    logic [31:0] mPc;
    logic [31:0] mInflight[$];
    logic [31:0] mBuf[$];
    int          mDrop;
    memEntry_t   memQ[$];
    int          lastDue;
    logic [31:0] consumedPc[$];
    int          consumedCycle[$];

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] ext(input logic b);
        return {31'b0, b};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic checkConsumed(input string tag, input int idx, input logic [31:0] exp);
        if (idx < consumedPc.size()) checkOutput(tag, consumedPc[idx], exp);
        else checkOutput({tag, "_count"}, consumedPc.size(), idx + 1);
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
    task automatic applyStimulus(input logic rstV, input logic readyV, input logic instrReadyV,
                                 input logic redirV, input logic [31:0] rpcV);
        logic        expReq;
        logic        expValid;
        logic        respV;
        logic        memResp;
        logic [31:0] respA;
        logic [31:0] pc;
        int          lat;
        int          due;
        @(negedge clk);
        rst                = rstV;
        bus.imem_req_ready = readyV;
        bus.instr_ready    = instrReadyV;
        bus.redirect_valid = redirV;
        bus.redirect_pc    = rpcV;
        respV   = 1'b0;
        memResp = 1'b0;
        respA   = '0;
        if (!rstV && memQ.size() > 0 && memQ[0].due <= cycle) begin
            respV   = 1'b1;
            memResp = 1'b1;
            respA   = memQ[0].addr;
        end else if (!rstV && spurious) begin
            respV = 1'b1;
            respA = 32'hDEAD_0000;
        end
        bus.imem_resp_valid = respV;
        bus.imem_resp_data  = respV ? memWord(respA) : 32'h0;
        #1;
        expReq   = !rstV && !redirV && (mInflight.size() + mBuf.size() < DEPTH);
        expValid = !rstV && (mBuf.size() > 0);
        checkOutput("req_valid", ext(bus.imem_req_valid), ext(expReq));
        if (expReq) checkOutput("req_addr", bus.imem_req_addr, mPc);
        checkOutput("instr_valid", ext(bus.instr_valid), ext(expValid));
        if (expValid) begin
            checkOutput("instr_pc", bus.instr_pc, mBuf[0]);
            checkOutput("instr", bus.instr, memWord(mBuf[0]));
        end else if (rstV) begin
            checkOutput("rst_instr", bus.instr, 32'h0);
            checkOutput("rst_instr_pc", bus.instr_pc, 32'h0);
        end
        if (memResp && mInflight.size() > 0) checkOutput("resp_addr", respA, mInflight[0]);

        if (bus.instr_valid === 1'b1 && instrReadyV) begin
            consumedPc.push_back(bus.instr_pc);
            consumedCycle.push_back(cycle);
        end

        if (rstV) begin
            mPc     = RESET_PC;
            mDrop   = 0;
            mInflight.delete();
            mBuf.delete();
            memQ.delete();
            lastDue = cycle;
        end else begin
            if (expValid && instrReadyV) void'(mBuf.pop_front());
            if (respV && mInflight.size() > 0) begin
                pc = mInflight.pop_front();
                if (redirV || mDrop > 0) begin
                    if (!redirV) mDrop--;
                    discardCount++;
                end else begin
                    mBuf.push_back(pc);
                end
            end
            if (redirV) begin
                mBuf.delete();
                mDrop = mInflight.size();
                mPc   = {rpcV[31:2], 2'b00};
            end else if (expReq && readyV) begin
                mInflight.push_back(mPc);
                mPc = mPc + 32'd4;
            end
            if (memResp) void'(memQ.pop_front());
            if (bus.imem_req_valid === 1'b1 && readyV) begin
                lat = int'($urandom_range(latMax, latMin));
                due = (cycle + lat > lastDue + 1) ? cycle + lat : lastDue + 1;
                memQ.push_back('{addr: bus.imem_req_addr, due: due});
                lastDue = due;
                acceptCount++;
            end
        end
        cycle++;
    endtask

    initial begin
        int startCycle;
        int startAccept;
        int discStart;
        logic redir;
        rst                 = 1'b1;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.instr_ready     = 1'b0;

        $display("[TB] reset and 1-cycle streaming");
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        consumedPc.delete();
        consumedCycle.delete();
        startCycle = cycle;
        repeat (12) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("stream_count", consumedPc.size(), 10);
        if (consumedCycle.size() > 0) checkOutput("stream_first_cycle", consumedCycle[0] - startCycle, 2);
        for (int i = 0; i < 10; i++) checkConsumed("stream_pc", i, i * 4);

        $display("[TB] decoder stall");
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        consumedPc.delete();
        startAccept = acceptCount;
        repeat (10) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("stall_accepts", acceptCount - startAccept, 4);
        checkOutput("stall_req_valid", ext(bus.imem_req_valid), 32'h0);
        repeat (8) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) checkConsumed("stall_resume_pc", i, i * 4);

        $display("[TB] redirect with requests outstanding");
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        latMin = 4;
        latMax = 4;
        discStart = discardCount;
        for (int i = 0; i < 20 && !(mInflight.size() == 3 && mBuf.size() == 1); i++)
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("redir_setup", ext(mInflight.size() == 3 && mBuf.size() == 1), 32'h1);
        latMin = 1;
        latMax = 1;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0103);
        consumedPc.delete();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("redir_flush_empty", ext(bus.instr_valid), 32'h0);
        repeat (10) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkOutput("redir_discards", discardCount - discStart, 3);
        checkConsumed("redir_target_pc", 0, 32'h0000_0100);

        $display("[TB] redirect with response and pop in the same cycle");
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        consumedPc.delete();
        repeat (6) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_2000);
        repeat (6) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkConsumed("same_cycle_pop", 4, 32'h0000_0010);
        checkConsumed("same_cycle_next", 5, 32'h0000_2000);

        $display("[TB] address wrap");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
        consumedPc.delete();
        repeat (8) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkConsumed("wrap_pc0", 0, 32'hFFFF_FFF8);
        checkConsumed("wrap_pc1", 1, 32'hFFFF_FFFC);
        checkConsumed("wrap_pc2", 2, 32'h0000_0000);
        checkConsumed("wrap_pc3", 3, 32'h0000_0004);

        $display("[TB] response with nothing outstanding");
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        spurious = 1'b1;
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        spurious = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("spurious_ignored", ext(bus.instr_valid), 32'h0);
        consumedPc.delete();
        repeat (6) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        checkConsumed("spurious_recover", 0, RESET_PC);

        $display("[TB] random latency, backpressure and redirects");
        repeat (2) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        latMin = 1;
        latMax = 5;
        for (int i = 0; i < 3000; i++) begin
            redir = ($urandom_range(99) < 4);
            applyStimulus(1'b0, ($urandom_range(3) != 0), ($urandom_range(2) != 0), redir, $urandom());
        end
        repeat (20) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
